// File: rtl/tlb_inv_walker.sv
`default_nettype none
// ============================================================================
// Module   : tlb_inv_walker
// Function : INVTLB engine; walks every TLB entry and clears the matching ones.
// Options  : INVTLB_FAST_CLEAR_EN - op0/op1 clear the whole TLB in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_inv_walker #(
    parameter int TLBNUM = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inv_en_i,
    input  logic [4:0]                inv_op_i,
    input  logic [9:0]                inv_asid_i,
    input  logic [18:0]               inv_vppn_i,
    output logic                      stall_o,
    output logic                      done_o,
    output logic [$clog2(TLBNUM)-1:0] rd_idx_o,
    input  logic                      rd_e_i,
    input  logic                      rd_g_i,
    input  logic [9:0]                rd_asid_i,
    input  logic [18:0]               rd_vppn_i,
    input  logic [5:0]                rd_ps_i,
    output logic                      clr_we_o,
`ifdef INVTLB_FAST_CLEAR_EN
    output logic                      clr_all_o,
`endif
    output logic [$clog2(TLBNUM)-1:0] clr_idx_o
);

    localparam int IDX_W = $clog2(TLBNUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WALK = 1'b1;

    localparam logic [4:0] OP_MAX_LEGAL = 5'd6;
    localparam logic [5:0] PS_4K        = 6'd12;
    localparam logic [5:0] PS_2M        = 6'd21;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [2:0]       op_q,    op_d;
    logic [9:0]       asid_q,  asid_d;
    logic [18:0]      vppn_q,  vppn_d;

    logic w_walk;
    logic w_last;
    logic w_legal;
    logic w_fast_op;
    logic w_req;
    logic w_start;
    logic w_asid_eq;
    logic w_va_match;
    logic w_hit;

    assign w_walk  = (state_q == S_WALK);
    assign w_last  = w_walk && (idx_q == LAST_IDX);
    assign w_legal = (inv_op_i <= OP_MAX_LEGAL);

`ifdef INVTLB_FAST_CLEAR_EN
    assign w_fast_op = (inv_op_i <= 5'd1);
`else
    assign w_fast_op = 1'b0;
`endif

    // Requests arriving mid-walk are dropped; ctrl holds commit while stalled.
    assign w_req   = !w_walk && inv_en_i && w_legal;
    assign w_start = w_req && !w_fast_op;

    // A 2MB page only compares the VPPN bits above the large-page offset.
    always_comb begin
        w_va_match = 1'b0;
        if (rd_ps_i == PS_4K) begin
            w_va_match = (rd_vppn_i == vppn_q);
        end else if (rd_ps_i == PS_2M) begin
            w_va_match = (rd_vppn_i[18:9] == vppn_q[18:9]);
        end
    end

    assign w_asid_eq = (rd_asid_i == asid_q);

    always_comb begin
        w_hit = 1'b0;
        case (op_q)
            3'd0, 3'd1: w_hit = 1'b1;
            3'd2:       w_hit = rd_g_i;
            3'd3:       w_hit = !rd_g_i;
            3'd4:       w_hit = !rd_g_i && w_asid_eq;
            3'd5:       w_hit = !rd_g_i && w_asid_eq && w_va_match;
            3'd6:       w_hit = (rd_g_i || w_asid_eq) && w_va_match;
            default:    w_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        asid_d  = asid_q;
        vppn_d  = vppn_q;
        if (w_start) begin
            state_d = S_WALK;
            idx_d   = '0;
            op_d    = inv_op_i[2:0];
            asid_d  = inv_asid_i;
            vppn_d  = inv_vppn_i;
        end else if (w_walk) begin
            idx_d = idx_q + IDX_ONE;
            if (w_last) begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            asid_q  <= '0;
            vppn_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            asid_q  <= asid_d;
            vppn_q  <= vppn_d;
        end
    end

    // Outputs are forced quiet during reset so an aborted walk clears nothing more.
    assign stall_o   = !rst && (w_walk || w_start);
    assign done_o    = !rst && (w_last || (w_req && w_fast_op));
    assign clr_we_o  = !rst && w_walk && rd_e_i && w_hit;
    assign rd_idx_o  = (!rst && w_walk) ? idx_q : '0;
    assign clr_idx_o = (!rst && w_walk) ? idx_q : '0;

`ifdef INVTLB_FAST_CLEAR_EN
    assign clr_all_o = !rst && w_req && w_fast_op;
`endif

endmodule
`default_nettype wire
